quad_decoder_param: RTL and testbench

- Parametrised quadrature decoder; successor to the fixed 8-bit single-mode decoder.
- Synchronises and glitch-filters the encoder A/B/Z inputs.
- Decodes Gray-code transitions in runtime-selectable x1/x2/x4 resolution into a signed position counter.
- Adds direction, step strobe, illegal-transition error and index (Z) homing.
- Sits between the encoder pins and the motion/readout logic.

---
 rtl/quad_decoder_param_if.sv | 38 +++
 rtl/quad_decoder_param.sv | 237 +++++++++++++++++++++++
 tb/tb_quad_decoder_param.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_decoder_param_if.sv
// -----------------------------------------------------------------------------
// quad_decoder_param_if
// Bundles the encoder pins, the control inputs and the decoded outputs of
// quad_decoder_param. COUNT_W must match the decoder instance it connects to.
//   A, B, Z     : raw encoder channels and index, asynchronous to clk
//   mode        : 00 = x1, 01 = x2, 10/11 = x4
//   clear       : synchronous zeroing of count, err and index_seen
//   count       : signed position (COUNT_W bits)
//   dir         : direction of last counted step (1 = up)
//   step        : one-cycle pulse on each count change
//   err         : sticky illegal-transition flag
//   index_seen  : sticky, set on a filtered Z rising edge
// master drives pins/controls and reads results; slave is the decoder.
// -----------------------------------------------------------------------------
interface quad_decoder_param_if #(
    parameter int COUNT_W = 16
);
    logic                      A;
    logic                      B;
    logic                      Z;
    logic [1:0]                mode;
    logic                      clear;
    logic signed [COUNT_W-1:0] count;
    logic                      dir;
    logic                      step;
    logic                      err;
    logic                      index_seen;

    modport master (
        output A, B, Z, mode, clear,
        input  count, dir, step, err, index_seen
    );

    modport slave (
        input  A, B, Z, mode, clear,
        output count, dir, step, err, index_seen
    );
endinterface

// File: rtl/quad_decoder_param.sv
// -----------------------------------------------------------------------------
// quad_decoder_param
// Parametrised quadrature decoder: synchronises and glitch-filters A/B/Z,
// decodes Gray-code transitions at x1/x2/x4 resolution into a signed position,
// and reports direction, step strobe, illegal transitions and index homing.
//   clk   : single rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : quad_decoder_param_if.slave (pins, mode, clear, decoded outputs)
// Raw A/B/Z edge to output update latency is SYNC_STAGES + FILT_LEN + 1 clocks.
// -----------------------------------------------------------------------------
module quad_decoder_param #(
    parameter int COUNT_W     = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int SATURATE    = 0,
    parameter int INDEX_CLR   = 1
) (
    input  logic                clk,
    input  logic                reset,
    quad_decoder_param_if.slave bus
);
    // Lane numbering inside the 3-bit per-input vectors.
    localparam int LA   = 2;
    localparam int LB   = 1;
    localparam int LZ   = 0;
    localparam int FW   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    // Clocks after reset release until the filter outputs reflect the pins.
    localparam int WARM = SYNC_STAGES + FILT_LEN;
    localparam int WW   = $clog2(WARM + 1);
    localparam logic signed [COUNT_W-1:0] CNT_MAX = {1'b0, {(COUNT_W-1){1'b1}}};
    localparam logic signed [COUNT_W-1:0] CNT_MIN = {1'b1, {(COUNT_W-1){1'b0}}};

    // Next Gray state in the up direction: 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] fwd_next(input logic [1:0] s);
        case (s)
            2'b00:   fwd_next = 2'b01;
            2'b01:   fwd_next = 2'b11;
            2'b11:   fwd_next = 2'b10;
            2'b10:   fwd_next = 2'b00;
            default: fwd_next = 2'b00;
        endcase
    endfunction

    logic [2:0]             raw_s;
    logic [2:0]             synced_s;
    logic [SYNC_STAGES-1:0] sync_q [3];
    logic [2:0]             filt_q, filt_d;
    logic [FW-1:0]          fcnt_q [3];
    logic [FW-1:0]          fcnt_d [3];

    logic [1:0]                cur_s;
    logic                      is_fwd_s, is_rev_s, illegal_s, b_edge_s;
    logic                      up_s, dn_s, z_rise_s;
    logic [WW-1:0]             warm_q, warm_d;
    logic [1:0]                prev_q, prev_d;
    logic                      primed_q, primed_d;
    logic                      zprev_q, zprev_d;
    logic signed [COUNT_W-1:0] count_q, count_d;
    logic                      dir_q, dir_d;
    logic                      step_q, step_d;
    logic                      err_q, err_d;
    logic                      idx_q, idx_d;

    assign raw_s = {bus.A, bus.B, bus.Z};

    // Last synchroniser stage of each lane.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            synced_s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Synchroniser shift registers, one chain per input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) sync_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw_s[i]};
        end
    end

    // Filter: the output flips on the FILT_LEN-th consecutive differing sample.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 3; i++) begin
            fcnt_d[i] = fcnt_q[i];
            if (synced_s[i] == filt_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] == FW'(FILT_LEN - 1)) begin
                filt_d[i] = synced_s[i];
                fcnt_d[i] = '0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + FW'(1);
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= 3'b000;
            for (int i = 0; i < 3; i++) fcnt_q[i] <= '0;
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < 3; i++) fcnt_q[i] <= fcnt_d[i];
        end
    end

    // Transition classification and counted-edge selection per mode.
    always_comb begin
        cur_s     = {filt_q[LA], filt_q[LB]};
        is_fwd_s  = (cur_s == fwd_next(prev_q));
        is_rev_s  = (prev_q == fwd_next(cur_s));
        illegal_s = primed_q && ((cur_s ^ prev_q) == 2'b11);
        b_edge_s  = (cur_s[0] != prev_q[0]);
        z_rise_s  = primed_q && filt_q[LZ] && !zprev_q;
        case (bus.mode)
            2'b00: begin
                up_s = (prev_q == 2'b00) && (cur_s == 2'b01);
                dn_s = (prev_q == 2'b01) && (cur_s == 2'b00);
            end
            2'b01: begin
                up_s = is_fwd_s && b_edge_s;
                dn_s = is_rev_s && b_edge_s;
            end
            default: begin
                up_s = is_fwd_s;
                dn_s = is_rev_s;
            end
        endcase
        up_s = up_s && primed_q;
        dn_s = dn_s && primed_q;
    end

    // Next state for priming, position, flags and strobe.
    always_comb begin
        warm_d   = warm_q;
        prev_d   = prev_q;
        primed_d = primed_q;
        zprev_d  = filt_q[LZ];
        count_d  = count_q;
        dir_d    = dir_q;
        step_d   = 1'b0;
        err_d    = err_q;
        idx_d    = idx_q;

        if (warm_q != WW'(WARM)) begin
            warm_d = warm_q + WW'(1);
        end else begin
            warm_d = warm_q;
        end

        // The first settled filter state becomes the reference, not a move.
        if (primed_q) begin
            prev_d = cur_s;
        end else if (warm_q == WW'(WARM)) begin
            prev_d   = cur_s;
            primed_d = 1'b1;
        end else begin
            prev_d = prev_q;
        end

        if (bus.clear) begin
            count_d = '0;
            err_d   = 1'b0;
            idx_d   = 1'b0;
        end else begin
            if (illegal_s) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
            if (z_rise_s && (INDEX_CLR != 0)) begin
                // Homing wins over a coincident step, which is dropped.
                idx_d   = 1'b1;
                count_d = '0;
            end else begin
                if (z_rise_s) begin
                    idx_d = 1'b1;
                end else begin
                    idx_d = idx_q;
                end
                if (up_s) begin
                    dir_d = 1'b1;
                    if ((SATURATE != 0) && (count_q == CNT_MAX)) begin
                        count_d = count_q;
                    end else begin
                        count_d = count_q + COUNT_W'(1);
                        step_d  = 1'b1;
                    end
                end else if (dn_s) begin
                    dir_d = 1'b0;
                    if ((SATURATE != 0) && (count_q == CNT_MIN)) begin
                        count_d = count_q;
                    end else begin
                        count_d = count_q - COUNT_W'(1);
                        step_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q;
                end
            end
        end
    end

    // Decoder state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warm_q   <= '0;
            prev_q   <= 2'b00;
            primed_q <= 1'b0;
            zprev_q  <= 1'b0;
            count_q  <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= 1'b0;
        end else begin
            warm_q   <= warm_d;
            prev_q   <= prev_d;
            primed_q <= primed_d;
            zprev_q  <= zprev_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.dir        = dir_q;
    assign bus.step       = step_q;
    assign bus.err        = err_q;
    assign bus.index_seen = idx_q;

endmodule

// File: tb/tb_quad_decoder_param.sv
// -----------------------------------------------------------------------------
// tb_quad_decoder_param
// Four decoder instances share the same pins: defaults, 4-bit wrapping,
// 4-bit saturating and index-without-clear. Expected step events for the
// instance under test are queued when a move is driven and popped whenever
// that instance pulses step.
// -----------------------------------------------------------------------------
module tb_quad_decoder_param;
    logic       clk = 1'b0;
    logic       reset;
    logic       a_r, b_r, z_r, clear_r;
    logic [1:0] mode_r;

    int total = 0;
    int bad   = 0;
    int sel   = 0;
    int exp_q [$];

    // Reference model state for the instance under test.
    logic [1:0] m_ab;
    logic       m_z;
    int         m_cnt, m_w, m_sat, m_iclr;
    logic [1:0] gray_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    logic              mon_step;
    logic signed [31:0] mon_cnt;
    int                mon_exp;

    always #5 clk = ~clk;

    quad_decoder_param_if #(.COUNT_W(16)) ifa ();
    quad_decoder_param_if #(.COUNT_W(4))  ifw ();
    quad_decoder_param_if #(.COUNT_W(4))  ifs ();
    quad_decoder_param_if #(.COUNT_W(16)) ifn ();

    assign ifa.A = a_r;  assign ifa.B = b_r;  assign ifa.Z = z_r;
    assign ifa.mode = mode_r;  assign ifa.clear = clear_r;
    assign ifw.A = a_r;  assign ifw.B = b_r;  assign ifw.Z = z_r;
    assign ifw.mode = mode_r;  assign ifw.clear = clear_r;
    assign ifs.A = a_r;  assign ifs.B = b_r;  assign ifs.Z = z_r;
    assign ifs.mode = mode_r;  assign ifs.clear = clear_r;
    assign ifn.A = a_r;  assign ifn.B = b_r;  assign ifn.Z = z_r;
    assign ifn.mode = mode_r;  assign ifn.clear = clear_r;

    quad_decoder_param #(.COUNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    quad_decoder_param #(.COUNT_W(4), .SATURATE(0)) dut_w (.clk(clk), .reset(reset), .bus(ifw));
    quad_decoder_param #(.COUNT_W(4), .SATURATE(1)) dut_s (.clk(clk), .reset(reset), .bus(ifs));
    quad_decoder_param #(.COUNT_W(16), .INDEX_CLR(0)) dut_n (.clk(clk), .reset(reset), .bus(ifn));

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int pos(input logic [1:0] s);
        case (s)
            2'b00:   pos = 0;
            2'b01:   pos = 1;
            2'b11:   pos = 2;
            default: pos = 3;
        endcase
    endfunction

    // Drive a new A/B/Z state and queue the step the model predicts.
    task automatic move(input logic [1:0] ab, input logic z, input int gap);
        int op, np, d, delta, nc, hi, lo;
        @(posedge clk); #1;
        op = pos(m_ab);
        np = pos(ab);
        d  = (np - op + 4) % 4;
        delta = 0;
        if (d == 1) begin
            case (mode_r)
                2'b00:   delta = (op == 0) ? 1 : 0;
                2'b01:   delta = (op % 2 == 0) ? 1 : 0;
                default: delta = 1;
            endcase
        end else if (d == 3) begin
            case (mode_r)
                2'b00:   delta = (np == 0) ? -1 : 0;
                2'b01:   delta = (np % 2 == 0) ? -1 : 0;
                default: delta = -1;
            endcase
        end
        hi = (1 << (m_w - 1)) - 1;
        lo = -(1 << (m_w - 1));
        if (z && !m_z && (m_iclr != 0)) begin
            m_cnt = 0;
        end else if (delta != 0) begin
            nc = m_cnt + delta;
            if ((nc > hi || nc < lo) && (m_sat != 0)) begin
                nc = m_cnt;
            end else begin
                if (nc > hi) nc = lo;
                if (nc < lo) nc = hi;
                exp_q.push_back(nc);
            end
            m_cnt = nc;
        end
        m_ab = ab;
        m_z  = z;
        a_r  = ab[1];
        b_r  = ab[0];
        z_r  = z;
        repeat (gap) @(posedge clk);
    endtask

    task automatic step_up(input int gap);
        move(gray_seq[(pos(m_ab) + 1) % 4], m_z, gap);
    endtask

    task automatic step_dn(input int gap);
        move(gray_seq[(pos(m_ab) + 3) % 4], m_z, gap);
    endtask

    task automatic do_reset(input logic [1:0] ab);
        @(posedge clk); #1;
        reset = 1'b1;
        a_r = ab[1]; b_r = ab[0]; z_r = 1'b0;
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        m_ab = ab; m_z = 1'b0; m_cnt = 0;
        repeat (12) @(posedge clk);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 clear_r = 1'b1;
        @(posedge clk); #1 clear_r = 1'b0;
        m_cnt = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(posedge clk); #1 mode_r = m;
    endtask

    // Scoreboard: every step pulse of the selected instance must be expected.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            case (sel)
                1:       begin mon_step = ifw.step; mon_cnt = ifw.count; end
                2:       begin mon_step = ifs.step; mon_cnt = ifs.count; end
                3:       begin mon_step = ifn.step; mon_cnt = ifn.count; end
                default: begin mon_step = ifa.step; mon_cnt = ifa.count; end
            endcase
            if (mon_step === 1'b1) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL step_unexpected observed=step count=%0d expected=no step", mon_cnt);
                end
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    check("step_count", mon_cnt, mon_exp);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; a_r = 1'b0; b_r = 1'b0; z_r = 1'b0;
        clear_r = 1'b0; mode_r = 2'b10;
        m_ab = 2'b00; m_z = 1'b0; m_cnt = 0; m_w = 16; m_sat = 0; m_iclr = 1;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_count", ifa.count, 0);
        check("rst_dir", ifa.dir, 0);
        check("rst_step", ifa.step, 0);
        check("rst_err", ifa.err, 0);
        check("rst_index", ifa.index_seen, 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (12) @(posedge clk);

        // x4 forward, first-pulse latency then seven more steps.
        sel = 0;
        step_up(0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("lat_early_step", ifa.step, 0);
        check("lat_early_count", ifa.count, 0);
        @(posedge clk);
        @(negedge clk);
        check("lat_step", ifa.step, 1);
        check("lat_count", ifa.count, 1);
        repeat (14) @(posedge clk);
        repeat (7) step_up(20);
        check("x4_count", ifa.count, 8);
        check("x4_dir", ifa.dir, 1);
        check("x4_sb_empty", exp_q.size(), 0);

        // x1 then x2: two forward cycles, one reverse cycle.
        pulse_clear();
        set_mode(2'b00);
        repeat (8) step_up(12);
        repeat (4) step_dn(12);
        check("x1_count", ifa.count, 1);
        check("x1_dir", ifa.dir, 0);
        pulse_clear();
        set_mode(2'b01);
        repeat (8) step_up(12);
        repeat (4) step_dn(12);
        check("x2_count", ifa.count, 2);
        check("x2_sb_empty", exp_q.size(), 0);

        // 4-bit wrapping.
        sel = 1; m_w = 4; m_sat = 0;
        set_mode(2'b10);
        do_reset(2'b00);
        repeat (7) step_up(10);
        check("wrap_at_max", ifw.count, 7);
        step_up(10);
        check("wrap_max_plus1", ifw.count, -8);
        step_dn(10);
        check("wrap_min_minus1", ifw.count, 7);
        check("wrap_sb_empty", exp_q.size(), 0);

        // 4-bit saturating.
        sel = 2; m_sat = 1;
        do_reset(2'b00);
        repeat (7) step_up(10);
        step_up(10);
        check("sat_hold_max", ifs.count, 7);
        check("sat_hold_max_dir", ifs.dir, 1);
        repeat (15) step_dn(10);
        check("sat_at_min", ifs.count, -8);
        step_dn(10);
        check("sat_hold_min", ifs.count, -8);
        check("sat_hold_min_dir", ifs.dir, 0);
        check("sat_sb_empty", exp_q.size(), 0);

        // Glitch rejection, illegal transition, clear.
        sel = 0; m_w = 16; m_sat = 0;
        do_reset(2'b00);
        step_up(12);
        @(posedge clk); #1 a_r = 1'b1;
        @(posedge clk); #1 a_r = 1'b0;
        repeat (12) @(posedge clk);
        check("glitch_count", ifa.count, 1);
        check("glitch_err", ifa.err, 0);
        move(2'b10, 1'b0, 12);
        check("illegal_err", ifa.err, 1);
        check("illegal_count", ifa.count, 1);
        pulse_clear();
        check("clear_err", ifa.err, 0);
        check("clear_count", ifa.count, 0);

        // Index coinciding with an up-step at count 5.
        do_reset(2'b10);
        repeat (5) step_up(10);
        check("pre_index_count", ifa.count, 5);
        move(2'b01, 1'b1, 12);
        check("index_clr_count", ifa.count, 0);
        check("index_clr_seen", ifa.index_seen, 1);
        check("index_noclr_count", ifn.count, 6);
        check("index_noclr_seen", ifn.index_seen, 1);
        check("index_sb_empty", exp_q.size(), 0);
        pulse_clear();
        check("clear_index", ifa.index_seen, 0);

        // Priming with A=B=1 held through reset, then async reset mid-run.
        do_reset(2'b11);
        check("prime_count", ifa.count, 0);
        check("prime_err", ifa.err, 0);
        move(2'b10, 1'b0, 12);
        check("after_prime_count", ifa.count, 1);
        check("after_prime_dir", ifa.dir, 1);
        @(posedge clk); #1 a_r = 1'b0; b_r = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_rst_count", ifa.count, 0);
        check("async_rst_dir", ifa.dir, 0);
        check("async_rst_step", ifa.step, 0);
        check("async_rst_err", ifa.err, 0);
        check("async_rst_index", ifa.index_seen, 0);
        check("final_sb_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
